// File: rtl/mul_pkg.sv
// Shared types and defaults for the signed multiplier operand feeder.
// Build option: MUL_FEEDER_TIMEOUT_EN enables the issue watchdog.
package mul_pkg;

    localparam int N_DEF     = 12;
    localparam int DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GUARD,
        WAIT
    } state_t;

    typedef struct packed {
        logic signed [N_DEF-1:0] a;
        logic signed [N_DEF-1:0] b;
    } pair_t;

endpackage

// File: rtl/mul_operand_feeder_if.sv
// Producer-side valid/ready bus carrying one signed operand pair.
// Transfer happens when in_valid and in_ready are both high at posedge.
interface mul_operand_feeder_if #(
    parameter int N = 12
) ();

    logic                in_valid;
    logic                in_ready;
    logic signed [N-1:0] in_a;
    logic signed [N-1:0] in_b;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        output in_ready
    );

endinterface

// File: rtl/mul_pair_fifo.sv
// Synchronous operand-pair FIFO with occupancy count.
// Pointers wrap modulo DEPTH; DEPTH must be a power of two.
module mul_pair_fifo
    import mul_pkg::*;
#(
    parameter int  DEPTH = DEPTH_DEF,
    parameter type T     = pair_t,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  T              wdata,
    output T              rdata,
    output logic [CW-1:0] count
);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign rdata   = mem[rd_ptr];

    // Storage needs no reset; it is only read once count says it is filled.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mul_operand_feeder.sv
// Queues signed operand pairs and issues them to a sequential multiplier.
// Build option: MUL_FEEDER_TIMEOUT_EN adds a sticky watchdog error.
module mul_operand_feeder
    import mul_pkg::*;
#(
    parameter int  N       = N_DEF,
    parameter int  DEPTH   = DEPTH_DEF,
    parameter int  TIMEOUT = N + 8,
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    mul_operand_feeder_if.slave in_bus,
    output logic                mul_start,
    output logic signed [N-1:0] mul_a,
    output logic signed [N-1:0] mul_b,
    input  logic                mul_ready,
    output logic                done,
    output logic                busy,
    output logic [CW-1:0]       count,
    output logic                err
);

    typedef struct packed {
        logic signed [N-1:0] a;
        logic signed [N-1:0] b;
    } op_t;

    op_t    wdata;
    op_t    head;
    logic   push;
    logic   pop;
    logic   fin;
    logic   tmo;
    logic   wd_hit;
    state_t state_q;
    state_t state_n;

    assign wdata.a         = in_bus.in_a;
    assign wdata.b         = in_bus.in_b;
    assign in_bus.in_ready = (count < CW'(DEPTH));
    assign push            = in_bus.in_valid && in_bus.in_ready;
    assign busy            = (state_q != IDLE);

    mul_pair_fifo #(
        .DEPTH (DEPTH),
        .T     (op_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (head),
        .count (count)
    );

`ifdef MUL_FEEDER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_q;

    // Counts cycles spent in GUARD/WAIT; the final one is TIMEOUT-1.
    assign wd_hit = (wd_q == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
            err  <= 1'b0;
        end else begin
            if (state_q == GUARD || state_q == WAIT) begin
                wd_q <= wd_q + 1'b1;
            end else begin
                wd_q <= '0;
            end
            if (tmo) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign wd_hit = 1'b0;
    assign err    = 1'b0;
`endif

    always_comb begin
        state_n = state_q;
        pop     = 1'b0;
        fin     = 1'b0;
        tmo     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count != '0 && mul_ready) begin
                    pop     = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                state_n = GUARD;
            end
            // mul_ready may still show the previous result here.
            GUARD: begin
                if (wd_hit) begin
                    tmo     = 1'b1;
                    state_n = IDLE;
                end else begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (mul_ready) begin
                    fin     = 1'b1;
                    state_n = IDLE;
                end else if (wd_hit) begin
                    tmo     = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_n;
            mul_start <= pop;
            done      <= fin;
            if (pop) begin
                mul_a <= head.a;
                mul_b <= head.b;
            end
        end
    end

endmodule

// File: tb/tb_mul_operand_feeder.sv
// Directed bench for mul_operand_feeder with a mock sequential multiplier.
// Define MUL_FEEDER_TIMEOUT_EN to also exercise the watchdog.
module tb_mul_operand_feeder;
    import mul_pkg::*;

    localparam int N     = 12;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                mul_start;
    logic                mul_ready;
    logic                done;
    logic                busy;
    logic                err;
    logic signed [N-1:0] mul_a;
    logic signed [N-1:0] mul_b;
    logic [CW-1:0]       count;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mul_operand_feeder_if #(.N(N)) in_bus ();

    mul_operand_feeder #(
        .N       (N),
        .DEPTH   (DEPTH),
        .TIMEOUT (20)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_bus    (in_bus),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_ready (mul_ready),
        .done      (done),
        .busy      (busy),
        .count     (count),
        .err       (err)
    );

    // Mock multiplier: ready drops one edge after start, rises 13 edges later.
    logic mock_ready = 1'b1;
    int   mock_cnt = 0;
    int   rdy_mode = 0;

    assign mul_ready = (rdy_mode == 0) ? mock_ready : (rdy_mode == 2);

    always @(posedge clk) begin
        if (mul_start) begin
            mock_ready <= 1'b0;
            mock_cnt   <= 13;
        end else if (mock_cnt > 1) begin
            mock_cnt <= mock_cnt - 1;
        end else if (mock_cnt == 1) begin
            mock_cnt   <= 0;
            mock_ready <= 1'b1;
        end
    end

    logic [2*N-1:0]      starts[$];
    int                  done_cnt = 0;
    int                  clash_cnt = 0;
    int                  chg_cnt = 0;
    logic signed [N-1:0] prev_a = '0;
    logic signed [N-1:0] prev_b = '0;

    always @(negedge clk) begin
        if (mul_start) starts.push_back({mul_a, mul_b});
        if (done) done_cnt++;
        if (mul_start && done) clash_cnt++;
        if (!mul_start && (mul_a !== prev_a || mul_b !== prev_b)) chg_cnt++;
        prev_a = mul_a;
        prev_b = mul_b;
    end

    task automatic clear_logs();
        starts.delete();
        done_cnt  = 0;
        clash_cnt = 0;
        chg_cnt   = 0;
    endtask

    task automatic push(input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clk);
        in_bus.in_valid = 1'b1;
        in_bus.in_a     = a;
        in_bus.in_b     = b;
        @(posedge clk);
        #1;
        in_bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 60; k++) begin
            if (mock_ready && !busy) break;
            @(negedge clk);
        end
        if (!(mock_ready && !busy)) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_idle: busy=%b mock_ready=%b, want 0/1", busy, mock_ready);
        end
    endtask

    task automatic wait_done(input int want);
        for (int k = 0; k < 300; k++) begin
            if (done_cnt >= want) break;
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_bus.in_valid = 1'b0;
        in_bus.in_a = '0;
        in_bus.in_b = '0;
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", count); end
        n_cmp++; if (mul_start !== 1'b0) begin n_fail++; $display("FAIL rst_start: got %b want 0", mul_start); end
        n_cmp++; if (mul_a !== 12'h000 || mul_b !== 12'h000) begin n_fail++; $display("FAIL rst_ab: got %h/%h want 0/0", mul_a, mul_b); end
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL rst_flags: busy=%b done=%b err=%b want 000", busy, done, err); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (in_bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_bus.in_ready); end

        push(12'd1, 12'd2);
        @(posedge clk);
        #1;
        rdy_mode = 1;
        n_cmp++; if (mul_start !== 1'b1 || mul_a !== 12'd1) begin n_fail++; $display("FAIL mid_issue: start=%b a=%h want 1/001", mul_start, mul_a); end
        push(12'd3, 12'd4);
        push(12'd5, 12'd6);
        push(12'd7, 12'd8);
        n_cmp++; if (busy !== 1'b1 || count !== 3'd3) begin n_fail++; $display("FAIL mid_wait: busy=%b count=%0d want 1/3", busy, count); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL arst_count: got %0d want 0", count); end
        n_cmp++; if (mul_start !== 1'b0 || mul_a !== 12'h000 || mul_b !== 12'h000) begin n_fail++; $display("FAIL arst_mul: start=%b a=%h b=%h want 0/0/0", mul_start, mul_a, mul_b); end
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL arst_flags: busy=%b done=%b want 00", busy, done); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (in_bus.in_ready !== 1'b1 || count !== 3'd0) begin n_fail++; $display("FAIL arst_release: in_ready=%b count=%0d want 1/0", in_bus.in_ready, count); end
    endtask

    task automatic test_single_op();
        int lat;
        rdy_mode = 0;
        wait_idle();
        clear_logs();
        lat = 0;
        push(12'hFFB, 12'h007);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
        n_cmp++; if (lat !== 17) begin n_fail++; $display("FAIL single_latency: got %0d want 17", lat); end
        repeat (3) @(negedge clk);
        n_cmp++; if (starts.size() !== 1) begin n_fail++; $display("FAIL single_starts: got %0d want 1", starts.size()); end
        if (starts.size() >= 1) begin
            n_cmp++; if (starts[0] !== {12'hFFB, 12'h007}) begin n_fail++; $display("FAIL single_ab: got %h want ffb007", starts[0]); end
        end
        n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL single_done: got %0d want 1", done_cnt); end
        n_cmp++; if (busy !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL single_idle: busy=%b count=%0d want 0/0", busy, count); end
    endtask

    task automatic test_fill_full();
        logic [2*N-1:0] exp_q[4];
        exp_q[0] = {12'd1, 12'd2};
        exp_q[1] = {12'd3, 12'd4};
        exp_q[2] = {12'd5, 12'd6};
        exp_q[3] = {12'd7, 12'd8};
        rdy_mode = 1;
        wait_idle();
        push(12'd1, 12'd2);
        push(12'd3, 12'd4);
        push(12'd5, 12'd6);
        push(12'd7, 12'd8);
        n_cmp++; if (count !== 3'd4 || in_bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full: count=%0d in_ready=%b want 4/0", count, in_bus.in_ready); end
        @(negedge clk);
        in_bus.in_valid = 1'b1;
        in_bus.in_a = 12'd9;
        in_bus.in_b = 12'd10;
        @(posedge clk);
        #1;
        in_bus.in_valid = 1'b0;
        n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_fifth: count=%0d want 4", count); end
        clear_logs();
        rdy_mode = 0;
        wait_done(4);
        n_cmp++; if (done_cnt !== 4 || starts.size() !== 4) begin n_fail++; $display("FAIL fill_drain: done=%0d starts=%0d want 4/4", done_cnt, starts.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < starts.size()) begin
                n_cmp++; if (starts[i] !== exp_q[i]) begin n_fail++; $display("FAIL fill_order%0d: got %h want %h", i, starts[i], exp_q[i]); end
            end
        end
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL fill_empty: count=%0d want 0", count); end
    endtask

    task automatic test_push_pop();
        rdy_mode = 1;
        wait_idle();
        push(12'd11, 12'd12);
        n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL pp_pre: count=%0d want 1", count); end
        @(negedge clk);
        rdy_mode = 2;
        in_bus.in_valid = 1'b1;
        in_bus.in_a = 12'd13;
        in_bus.in_b = 12'd14;
        @(posedge clk);
        #1;
        in_bus.in_valid = 1'b0;
        n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL pp_count: count=%0d want 1", count); end
        n_cmp++; if (mul_start !== 1'b1 || mul_a !== 12'd11 || mul_b !== 12'd12) begin n_fail++; $display("FAIL pp_older: start=%b a=%h b=%h want 1/00b/00c", mul_start, mul_a, mul_b); end
        repeat (10) @(negedge clk);
        n_cmp++; if (count !== 3'd0 || mul_a !== 12'd13 || mul_b !== 12'd14) begin n_fail++; $display("FAIL pp_second: count=%0d a=%h b=%h want 0/00d/00e", count, mul_a, mul_b); end
        rdy_mode = 0;
    endtask

    task automatic test_back_to_back();
        logic [2*N-1:0] exp_q[3];
        exp_q[0] = {12'h015, 12'hFEA};
        exp_q[1] = {12'h800, 12'h7FF};
        exp_q[2] = {12'h123, 12'h456};
        rdy_mode = 0;
        wait_idle();
        clear_logs();
        push(12'h015, 12'hFEA);
        push(12'h800, 12'h7FF);
        push(12'h123, 12'h456);
        wait_done(3);
        n_cmp++; if (done_cnt !== 3) begin n_fail++; $display("FAIL b2b_done: got %0d want 3", done_cnt); end
        n_cmp++; if (clash_cnt !== 0) begin n_fail++; $display("FAIL b2b_clash: got %0d want 0", clash_cnt); end
        n_cmp++; if (chg_cnt !== 0) begin n_fail++; $display("FAIL b2b_stable: got %0d changes want 0", chg_cnt); end
        n_cmp++; if (starts.size() !== 3) begin n_fail++; $display("FAIL b2b_starts: got %0d want 3", starts.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < starts.size()) begin
                n_cmp++; if (starts[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_order%0d: got %h want %h", i, starts[i], exp_q[i]); end
            end
        end
    endtask

`ifdef MUL_FEEDER_TIMEOUT_EN
    task automatic test_timeout();
        int lat;
        rdy_mode = 2;
        wait_idle();
        clear_logs();
        lat = 0;
        push(12'd5, 12'd5);
        @(posedge clk);
        #1;
        rdy_mode = 1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (err) begin
                lat = k;
                break;
            end
        end
        n_cmp++; if (lat !== 22) begin n_fail++; $display("FAIL tmo_latency: got %0d want 22", lat); end
        n_cmp++; if (done_cnt !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL tmo_state: done=%0d busy=%b want 0/0", done_cnt, busy); end
        repeat (5) @(negedge clk);
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b want 1", err); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL tmo_clear: got %b want 0", err); end
        @(negedge clk);
        rst_n = 1'b1;
        rdy_mode = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_op();
        test_fill_full();
        test_push_pop();
        test_back_to_back();
`ifdef MUL_FEEDER_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_operand_feeder.md
Name: mul_operand_feeder

Overview:
- Upstream stage for the N-bit signed sequential multiplier (ports clk, start, A, B, Product, ready).
- Buffers signed operand pairs from a producer in a small FIFO and issues them one at a time.
- Issue means driving a one-cycle start pulse with stable A/B, then waiting for the multiplier's ready before issuing the next pair.
- Provides a done pulse per completed multiplication so a downstream consumer knows when Product is valid.

Parameters:
- N, 12, operand width in bits (signed); must match the multiplier's N.
- DEPTH, 4, operand-pair FIFO depth; power of two, at least 2.
- TIMEOUT, N+8, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer offers {in_a, in_b}.
- in_ready  out  1  FIFO can accept; transfer occurs when in_valid & in_ready at posedge.
- in_a  in  N  signed operand A.
- in_b  in  N  signed operand B.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_a  out  N  operand A to the multiplier, registered.
- mul_b  out  N  operand B to the multiplier, registered.
- mul_ready  in  1  multiplier ready/done (high when idle or result valid).
- done  out  1  one-cycle pulse: the issued multiplication has completed.
- busy  out  1  high in any state other than IDLE.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- err  out  1  sticky watchdog error (optional feature; tied 0 otherwise).

Behaviour:
- Reset (rst_n=0, asynchronous) forces:
  - count=0 and FIFO pointers=0.
  - state=IDLE.
  - mul_start=0, mul_a=0, mul_b=0, done=0, err=0.
  - in_ready=1 once released.
- Reset mid-operation abandons the in-flight multiplication and discards queued pairs. The multiplier itself has no reset, so IDLE never issues until mul_ready=1.
- FIFO:
  - in_ready = (count < DEPTH), derived from the registered count.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
  - Push while full is impossible because in_ready=0.
- FSM states: IDLE, ISSUE, GUARD, WAIT.
  - IDLE: if count>0 and mul_ready=1, then at posedge pop the head pair into mul_a/mul_b, set mul_start=1, go to ISSUE. Otherwise stay.
  - ISSUE: mul_start=1 for exactly this cycle; the multiplier samples A/B at the closing edge. Go to GUARD; mul_start returns to 0.
  - GUARD: one cycle in which mul_ready is ignored, covering the multiplier's ready-drop latency. Go to WAIT.
  - WAIT: on mul_ready=1, pulse done=1 for one cycle and return to IDLE.
- Issue timing:
  - The earliest re-issue is the cycle after done; done and the next mul_start never coincide.
  - A pair pushed into an empty FIFO while IDLE with mul_ready=1 is issued 1 cycle later (the first posedge sees count=1).
- mul_a/mul_b hold their values from issue until the next issue. They never go X and never change while the multiplier is busy.
- Pairs are issued in push order with no reordering or dropping.
- The feeder performs no arithmetic; operands pass bit-exact as signed N-bit values.

Optional Feature:
- MUL_FEEDER_TIMEOUT_EN defined:
  - A cycle counter runs in GUARD/WAIT.
  - If it reaches TIMEOUT without mul_ready, set err=1 (sticky until reset), return to IDLE, and do not pulse done.
  - The pair in flight is lost.
- Not defined: no counter, err tied to 0, and WAIT waits indefinitely.

Decomposition:
- Shared package mul_pkg:
  - state enum (IDLE, ISSUE, GUARD, WAIT).
  - default N and DEPTH constants.
  - typedef for a signed N-bit operand pair struct {a, b}.
- One natural sub-module: mul_pair_fifo (synchronous FIFO with count, async active-low reset).
- The FSM and watchdog stay in the top level.

Test Plan:
- Reset: hold rst_n=0 mid-WAIT with count=3 -> immediately count=0, mul_start=0, mul_a=mul_b=0, busy=0, done=0; after release, in_ready=1.
- Single op: push A=-5 (0xFFB), B=7, with mock multiplier (ready drops 1 cycle after start, rises 13 cycles later) -> exactly one mul_start pulse with mul_a=0xFFB, mul_b=0x007; done pulses once when ready rises; busy low afterwards.
- Fill/full: push 4 pairs back-to-back while mul_ready=0 -> count=4, in_ready=0. A fifth in_valid is not accepted. Then raise mul_ready -> issued in push order (1,2), (3,4), (5,6), (7,8).
- Simultaneous push/pop: count=1 in IDLE, mul_ready=1, push in the same cycle -> count stays 1; the popped pair is the older one.
- Back-to-back: 3 pairs queued -> no mul_start ever in the same cycle as done. mul_a/mul_b are stable from every start until the next start. Exactly 3 done pulses.
- With MUL_FEEDER_TIMEOUT_EN: mul_ready held 0 after start -> err=1 after TIMEOUT=20 cycles in GUARD/WAIT, no done, state returns to IDLE; err stays 1 until rst_n=0.
